// File: rtl/mul_radix4_sequencer_if.sv
// Requester <-> radix-4 multiply sequencer handshake and operand/result bus.
interface mul_radix4_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                 iStart;
    logic                 iAbort;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic                 oBusy;
    logic                 oDone;
    logic [1:0]           oSel;
    logic [2*WIDTH-1:0]   oResult;

    // Requester side
    modport master (
        output iStart, iAbort, iA, iB,
        input  oBusy, oDone, oSel, oResult
    );

    // Sequencer side
    modport slave (
        input  iStart, iAbort, iA, iB,
        output oBusy, oDone, oSel, oResult
    );
endinterface

// File: rtl/mul_radix4_sequencer.sv
// Radix-4 shift-add multiply sequencer: retires two multiplier bits per RUN
// cycle, accumulating 0/A/2A/3A shifted by the digit position.
module mul_radix4_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    mul_radix4_sequencer_if.slave  bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     ra_q, ra_d;
    logic [WIDTH-1:0]     rb_q, rb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [1:0]           sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH+1:0]     pp;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     rb_shift;
    logic                 last_digit;

    // Partial product for the current digit and the accumulator update.
    // rB is shifted right each RUN cycle so the current digit always sits in
    // rb_q[1:0]; the shift of the partial product still follows cnt.
    always_comb begin
        unique case (rb_q[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = {2'b00, ra_q};
            2'b10:   pp = {1'b0, ra_q, 1'b0};
            default: pp = {2'b00, ra_q} + {1'b0, ra_q, 1'b0};
        endcase
        acc_next   = acc_q + ((2*WIDTH)'(pp) << {cnt_q, 1'b0});
        rb_shift   = rb_q >> 2;
        last_digit = (cnt_q == CW'(N - 1));
    end

    // Next-state logic for the IDLE/RUN/DONE controller and its registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    ra_d    = bus.iA;
                    rb_d    = bus.iB;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sel_d   = bus.iB[1:0];
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.iAbort) begin
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (last_digit) begin
                    acc_d   = acc_next;
                    res_d   = acc_next;
                    rb_d    = rb_shift;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    acc_d   = acc_next;
                    rb_d    = rb_shift;
                    sel_d   = rb_shift[1:0];
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any operation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.oBusy   = busy_q;
    assign bus.oDone   = done_q;
    assign bus.oSel    = sel_q;
    assign bus.oResult = res_q;
endmodule

// File: tb/tb_mul_radix4_sequencer.sv
// Randomized bench for the radix-4 multiply sequencer against a plain
// multiplication reference.
module tb_mul_radix4_sequencer;
    localparam int W = 16;
    localparam int N = W / 2;

    logic Clock;
    logic Reset;
    int   npass;
    int   ntotal;
    logic [2*W-1:0] prev_res;

    mul_radix4_sequencer_if #(.WIDTH(W)) bus ();

    mul_radix4_sequencer #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference product: plain unsigned multiply.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Drives one multiply and records what the DUT shows; starts in IDLE.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [2*W-1:0] res,
                           output logic [W-1:0] trace, output logic [2*W-1:0] res_mid,
                           output logic done_after, output logic busy_first);
        @(posedge Clock);
        #1;
        bus.iStart = 1'b1;
        bus.iA     = a;
        bus.iB     = b;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        bus.iA     = W'($urandom);
        bus.iB     = W'($urandom);
        lat        = -1;
        res        = '0;
        trace      = '0;
        res_mid    = '0;
        busy_first = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock);
            if (cyc == 1) busy_first = bus.oBusy;
            if (bus.oDone) begin
                lat = cyc - 1;
                res = bus.oResult;
                break;
            end
            if (cyc <= N) trace[2*(cyc-1) +: 2] = bus.oSel;
            if (cyc == N / 2) res_mid = bus.oResult;
        end
        @(negedge Clock);
        done_after = bus.oDone;
    endtask

    task automatic test_reset();
        int busy_seen;
        Reset      = 1'b0;
        bus.iStart = 1'b0;
        bus.iAbort = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        ntotal++;
        if ({bus.oBusy, bus.oDone, bus.oSel, bus.oResult} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b sel=%b res=%h, want all 0",
                     bus.oBusy, bus.oDone, bus.oSel, bus.oResult);
        else npass++;
        Reset = 1'b1;
        busy_seen = 0;
        repeat (20) begin
            @(negedge Clock);
            if (bus.oBusy || bus.oDone) busy_seen++;
        end
        ntotal++;
        if (busy_seen !== 0) $display("FAIL idle_no_start: busy/done cycles=%0d, want 0", busy_seen);
        else npass++;
        prev_res = '0;
    endtask

    task automatic test_basic();
        int lat; logic [2*W-1:0] res, mid; logic [W-1:0] tr; logic dn, bz;
        run_one(16'd3, 16'd5, lat, res, tr, mid, dn, bz);
        ntotal++;
        if (bz !== 1'b1) $display("FAIL basic_busy: got %b, want 1", bz); else npass++;
        ntotal++;
        if (lat !== N) $display("FAIL basic_latency: got %0d, want %0d", lat, N); else npass++;
        ntotal++;
        if (res !== 32'd15) $display("FAIL basic_result: got %0d, want 15", res); else npass++;
        ntotal++;
        if (tr !== 16'h0005) $display("FAIL basic_sel_trace: got %h, want 0005", tr); else npass++;
        ntotal++;
        if (dn !== 1'b0) $display("FAIL basic_done_width: oDone after pulse=%b, want 0", dn); else npass++;
        prev_res = 32'd15;
    endtask

    task automatic test_corners();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        int lat; logic [2*W-1:0] res, mid, exp; logic [W-1:0] tr; logic dn, bz;
        av[0] = 16'hFFFF; bv[0] = 16'hFFFF;
        av[1] = 16'h0000; bv[1] = 16'h1234;
        av[2] = 16'hFFFF; bv[2] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            run_one(av[i], bv[i], lat, res, tr, mid, dn, bz);
            exp = ref_mul(av[i], bv[i]);
            ntotal++;
            if (res !== exp) $display("FAIL corner_result[%0d]: got %h, want %h", i, res, exp);
            else npass++;
            ntotal++;
            if (mid !== prev_res) $display("FAIL corner_hold[%0d]: mid-run result %h, want %h", i, mid, prev_res);
            else npass++;
            prev_res = exp;
        end
    endtask

    task automatic test_random();
        int lat; logic [2*W-1:0] res, mid, exp; logic [W-1:0] a, b, tr; logic dn, bz;
        int bad_res, bad_lat, bad_sel, bad_hold, bad_pulse;
        bad_res = 0; bad_lat = 0; bad_sel = 0; bad_hold = 0; bad_pulse = 0;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            run_one(a, b, lat, res, tr, mid, dn, bz);
            exp = ref_mul(a, b);
            if (res !== exp) begin
                bad_res++;
                $display("FAIL random_result: a=%h b=%h got %h want %h", a, b, res, exp);
            end
            if (lat !== N || bz !== 1'b1) bad_lat++;
            if (tr !== b) bad_sel++;
            if (mid !== prev_res) bad_hold++;
            if (dn !== 1'b0) bad_pulse++;
            prev_res = exp;
        end
        ntotal++;
        if (bad_res !== 0) $display("FAIL random_results: bad=%0d, want 0", bad_res); else npass++;
        ntotal++;
        if (bad_lat !== 0) $display("FAIL random_latency: bad=%0d, want 0", bad_lat); else npass++;
        ntotal++;
        if (bad_sel !== 0) $display("FAIL random_sel: bad=%0d, want 0", bad_sel); else npass++;
        ntotal++;
        if (bad_hold !== 0) $display("FAIL random_result_hold: bad=%0d, want 0", bad_hold); else npass++;
        ntotal++;
        if (bad_pulse !== 0) $display("FAIL random_done_width: bad=%0d, want 0", bad_pulse); else npass++;
    endtask

    task automatic test_back_to_back();
        int done_at [3];
        int ndone, bad_res, wide;
        logic prev_done;
        ndone = 0; bad_res = 0; wide = 0; prev_done = 1'b0;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'd7;
        bus.iB     = 16'd9;
        for (int cyc = 0; cyc < 60 && ndone < 3; cyc++) begin
            @(negedge Clock);
            if (bus.oDone) begin
                if (prev_done) wide++;
                done_at[ndone] = cyc;
                ndone++;
                if (bus.oResult !== 32'd63) bad_res++;
            end
            prev_done = bus.oDone;
            if (ndone == 3) bus.iStart = 1'b0;
            if (bus.oBusy) bus.iB = W'($urandom);
            else           bus.iB = 16'd9;
        end
        bus.iStart = 1'b0;
        ntotal++;
        if (ndone !== 3) $display("FAIL b2b_done_count: got %0d, want 3", ndone); else npass++;
        ntotal++;
        if (bad_res !== 0 || wide !== 0)
            $display("FAIL b2b_result: bad results=%0d wide pulses=%0d, want 0/0", bad_res, wide);
        else npass++;
        ntotal++;
        if (ndone == 3 && (done_at[1] - done_at[0] !== N + 2 || done_at[2] - done_at[1] !== N + 2))
            $display("FAIL b2b_period: got %0d,%0d, want %0d", done_at[1] - done_at[0],
                     done_at[2] - done_at[1], N + 2);
        else npass++;
        @(negedge Clock);
        @(negedge Clock);
        prev_res = 32'd63;
    endtask

    // Abort after abort_edge-1 accumulating RUN edges.
    task automatic test_abort(input int abort_edge);
        int dones;
        int lat; logic [2*W-1:0] res, mid; logic [W-1:0] tr; logic dn, bz;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'd100;
        bus.iB     = 16'd200;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        repeat (abort_edge - 1) @(posedge Clock);
        #1;
        bus.iAbort = 1'b1;
        @(posedge Clock);
        #1;
        bus.iAbort = 1'b0;
        @(negedge Clock);
        ntotal++;
        if (bus.oBusy !== 1'b0 || bus.oResult !== prev_res || bus.oSel !== 2'b00)
            $display("FAIL abort%0d_state: busy=%b sel=%b res=%h, want 0/00/%h",
                     abort_edge, bus.oBusy, bus.oSel, bus.oResult, prev_res);
        else npass++;
        dones = 0;
        repeat (12) begin
            @(negedge Clock);
            if (bus.oDone) dones++;
        end
        ntotal++;
        if (dones !== 0) $display("FAIL abort%0d_no_done: got %0d pulses, want 0", abort_edge, dones);
        else npass++;
        run_one(16'd100, 16'd200, lat, res, tr, mid, dn, bz);
        ntotal++;
        if (res !== 32'd20000 || lat !== N)
            $display("FAIL abort%0d_restart: got %0d lat %0d, want 20000 lat %0d", abort_edge, res, lat, N);
        else npass++;
        prev_res = 32'd20000;
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'd1234;
        bus.iB     = 16'd4321;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        repeat (2) @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        ntotal++;
        if ({bus.oBusy, bus.oDone, bus.oSel, bus.oResult} !== '0)
            $display("FAIL async_reset_outputs: busy=%b done=%b sel=%b res=%h, want all 0",
                     bus.oBusy, bus.oDone, bus.oSel, bus.oResult);
        else npass++;
        @(negedge Clock);
        Reset = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge Clock);
            if (bus.oDone || bus.oBusy) seen++;
        end
        ntotal++;
        if (seen !== 0) $display("FAIL async_reset_quiet: busy/done cycles=%0d, want 0", seen);
        else npass++;
        prev_res = '0;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_abort(4);
        test_abort(N);
        test_async_reset();
        test_basic();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
